memout_stream_reader: RTL and testbench

//  Downstream readout stage for the paged output BRAM written by the processing top.
//  On each BX change it reads the page filled during the previous BX, entries 0..nent-1.
//  It streams the entries out on a valid/ready interface, tagged with the BX they belong to.
//  It drives the BRAM port-B controls (enb, addrb, pageb) and absorbs the BRAM read latency.
//  A small credit-controlled FIFO provides that absorption, so back-pressure never loses data.

---
 rtl/memout_stream_reader.sv | 162 ++++++++++++++++
 tb/tb_memout_stream_reader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memout_stream_reader.sv
// Streams the page written during the previous BX out of the paged BRAM, tagged with that BX.
// First entry appears LATENCY+2 cycles after a BX change; a credit-guarded FIFO absorbs out_ready stalls losslessly.
module memout_stream_reader #(
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 16,
  parameter int PAGES      = 2,
  parameter int NENT_W     = 5,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en_proc,
  input  logic [1:0]                   bx_in,
  input  logic [PAGES*NENT_W-1:0]      nent_all,
  output logic                         rd_en,
  output logic [$clog2(PAGES)-1:0]     rd_page,
  output logic [$clog2(RAM_DEPTH)-1:0] rd_addr,
  input  logic [RAM_WIDTH-1:0]         rd_data,
  output logic [RAM_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_bx,
  output logic                         done,
  output logic                         trunc
);

  localparam int PGW  = $clog2(PAGES);
  localparam int AW   = $clog2(RAM_DEPTH);
  localparam int CNTW = $clog2(RAM_DEPTH + 1);
  localparam int FPW  = $clog2(FIFO_DEPTH);
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int IFW  = $clog2(LATENCY + 1);
  localparam int USEW = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_bx_d;
  logic [1:0]           r_out_bx;
  logic [PGW-1:0]       r_page;
  logic [PGW-1:0]       w_page_nxt;
  logic [NENT_W-1:0]    w_nent;
  logic [CNTW-1:0]      w_cnt_nxt;
  logic [CNTW-1:0]      r_cnt;
  logic [CNTW-1:0]      r_issue;
  logic [LATENCY-1:0]   r_pipe;
  logic [IFW-1:0]       w_inflight;
  logic                 w_new_bx;
  logic                 w_credit_ok;
  logic                 w_push;
  logic                 w_pop;
  logic [RAM_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [FPW-1:0]       r_wptr;
  logic [FPW-1:0]       r_rptr;
  logic [FCW-1:0]       r_count;

  function automatic logic [FPW-1:0] f_inc(input logic [FPW-1:0] p);
    return (p == FPW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_new_bx   = en_proc && (bx_in != r_bx_d);
  assign w_page_nxt = PGW'(32'(r_bx_d) % PAGES);
  assign w_nent     = nent_all[int'(w_page_nxt) * NENT_W +: NENT_W];
  assign w_cnt_nxt  = (int'(w_nent) > RAM_DEPTH) ? CNTW'(RAM_DEPTH) : CNTW'(w_nent);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + IFW'(r_pipe[i]);
    end
  end

  // Reads still in the latency pipe already own a FIFO slot.
  assign w_credit_ok = (USEW'(r_count) + USEW'(w_inflight)) < USEW'(FIFO_DEPTH);
  assign w_push      = r_pipe[LATENCY-1];
  assign w_pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_new_bx) begin
      w_state_nxt = S_READ;
    end else begin
      case (r_state)
        S_READ:  if (r_issue == r_cnt) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_inflight == '0 && r_count == '0) w_state_nxt = S_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_en = 1'b0;
    done  = 1'b0;
    case (r_state)
      S_READ:  rd_en = (r_issue < r_cnt) && w_credit_ok;
      S_DRAIN: done  = !w_new_bx && w_inflight == '0 && r_count == '0;
      default: ;
    endcase
    trunc = w_new_bx && (r_state != S_IDLE);
  end

  // A new BX also discards any reads of the aborted page still in the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bx_d   <= '0;
      r_out_bx <= '0;
      r_page   <= '0;
      r_cnt    <= '0;
      r_issue  <= '0;
      r_pipe   <= '0;
    end else begin
      r_bx_d <= bx_in;
      if (w_new_bx) begin
        r_page   <= w_page_nxt;
        r_out_bx <= r_bx_d;
        r_cnt    <= w_cnt_nxt;
        r_issue  <= '0;
        r_pipe   <= '0;
      end else begin
        if (rd_en) r_issue <= r_issue + 1'b1;
        r_pipe <= (r_pipe << 1) | LATENCY'(rd_en);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_new_bx) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= rd_data;
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_fifo[r_rptr] : '0;
  assign out_bx    = r_out_bx;
  assign rd_page   = r_page;
  assign rd_addr   = r_issue[AW-1:0];

endmodule

// File: tb/tb_memout_stream_reader.sv
// Bench for memout_stream_reader: directed vector table, corner sequences and a randomized scoreboard run.
module tb_memout_stream_reader;

  localparam int RW = 32;
  localparam int RD = 16;
  localparam int PG = 2;
  localparam int NW = 5;
  localparam int LAT = 2;
  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            en_proc;
  logic [1:0]      bx_in;
  logic [PG*NW-1:0] nent_all;
  logic            rd_en;
  logic [0:0]      rd_page;
  logic [3:0]      rd_addr;
  logic [RW-1:0]   rd_data;
  logic [RW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_bx;
  logic            done;
  logic            trunc;

  always #5 clk = ~clk;

  memout_stream_reader #(
    .RAM_WIDTH(RW), .RAM_DEPTH(RD), .PAGES(PG), .NENT_W(NW), .LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .bx_in(bx_in), .nent_all(nent_all),
    .rd_en(rd_en), .rd_page(rd_page), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_bx(out_bx),
    .done(done), .trunc(trunc)
  );

  // Two-stage registered BRAM read port.
  logic [RW-1:0] mem [PG][RD];
  logic [RW-1:0] b_s1 = '0;
  logic [RW-1:0] b_s2 = '0;
  always @(posedge clk) begin
    if (rd_en) b_s1 <= mem[rd_page][rd_addr];
    b_s2 <= b_s1;
  end
  assign rd_data = b_s2;

  typedef struct {
    logic        rdy;
    logic [1:0]  bx;
    logic        e_rd_en;
    logic [3:0]  e_addr;
    logic        e_vld;
    logic [31:0] e_dat;
    logic        e_done;
    logic        e_trunc;
  } vec_t;

  int n_cmp, n_err;
  int issued, popped, credit_viol, stab_viol, page_viol;
  int done_cnt, trunc_cnt, valid_cycles, rd_cycles, first_addr;
  logic [0:0]  exp_page;
  logic        prev_stall;
  logic [33:0] prev_word;
  logic [33:0] got_q[$];

  logic        s_rd_en, s_out_valid, s_done, s_trunc;
  logic [0:0]  s_rd_page;
  logic [3:0]  s_rd_addr;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_bx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    issued = 0; popped = 0; credit_viol = 0; stab_viol = 0; page_viol = 0;
    done_cnt = 0; trunc_cnt = 0; valid_cycles = 0; rd_cycles = 0; first_addr = -1;
    prev_stall = 1'b0; prev_word = '0;
    got_q.delete();
  endtask

  // Samples one cycle at the falling edge, then returns just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_rd_en = rd_en; s_rd_page = rd_page; s_rd_addr = rd_addr; s_out_valid = out_valid;
    s_out_data = out_data; s_out_bx = out_bx; s_done = done; s_trunc = trunc;
    if (prev_stall && (!out_valid || {out_bx, out_data} != prev_word)) stab_viol++;
    prev_stall = out_valid && !out_ready;
    prev_word  = {out_bx, out_data};
    if (rd_en) begin
      if (issued - popped >= FD) credit_viol++;
      if (rd_page != exp_page) page_viol++;
      if (first_addr < 0) first_addr = int'(rd_addr);
      issued++;
      rd_cycles++;
    end
    if (out_valid) begin
      valid_cycles++;
      if (out_ready) begin
        got_q.push_back({out_bx, out_data});
        popped++;
      end
    end
    if (done)  done_cnt++;
    if (trunc) trunc_cnt++;
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready held, 1: random, 2: toggled every cycle
  task automatic run_until_done(input int budget, input int mode);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (mode == 1)      out_ready = ($urandom_range(0, 9) < 7);
      else if (mode == 2) out_ready = ~out_ready;
      tick();
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, " rd_en"},     s_rd_en, 0);
    check({pfx, " rd_page"},   s_rd_page, 0);
    check({pfx, " rd_addr"},   s_rd_addr, 0);
    check({pfx, " out_valid"}, s_out_valid, 0);
    check({pfx, " out_data"},  s_out_data, 0);
    check({pfx, " out_bx"},    s_out_bx, 0);
    check({pfx, " done"},      s_done, 0);
    check({pfx, " trunc"},     s_trunc, 0);
  endtask

  initial begin
    vec_t vt[9];
    n_cmp = 0; n_err = 0;
    reset = 1'b1; en_proc = 1'b1; bx_in = 2'd0; nent_all = '0; out_ready = 1'b0;
    for (int p = 0; p < PG; p++)
      for (int a = 0; a < RD; a++) mem[p][a] = 32'h1000_0000 + (p << 8) + a;
    clear_stats();
    exp_page = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_all_zero("reset");

    // bx 0->1, page 0 holds A,B,C; ready held high
    mem[0][0] = 32'hAAAA_0001; mem[0][1] = 32'hBBBB_0002; mem[0][2] = 32'hCCCC_0003;
    nent_all = {5'd0, 5'd3};
    vt[0] = '{1'b1, 2'd1, 1'b0, 4'd0, 1'b0, 32'h0,         1'b0, 1'b0};
    vt[1] = '{1'b1, 2'd1, 1'b1, 4'd0, 1'b0, 32'h0,         1'b0, 1'b0};
    vt[2] = '{1'b1, 2'd1, 1'b1, 4'd1, 1'b0, 32'h0,         1'b0, 1'b0};
    vt[3] = '{1'b1, 2'd1, 1'b1, 4'd2, 1'b0, 32'h0,         1'b0, 1'b0};
    vt[4] = '{1'b1, 2'd1, 1'b0, 4'd3, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0};
    vt[5] = '{1'b1, 2'd1, 1'b0, 4'd3, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0};
    vt[6] = '{1'b1, 2'd1, 1'b0, 4'd3, 1'b1, 32'hCCCC_0003, 1'b0, 1'b0};
    vt[7] = '{1'b1, 2'd1, 1'b0, 4'd3, 1'b0, 32'h0,         1'b1, 1'b0};
    vt[8] = '{1'b1, 2'd1, 1'b0, 4'd3, 1'b0, 32'h0,         1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      out_ready = vt[i].rdy;
      bx_in     = vt[i].bx;
      tick();
      check($sformatf("t1[%0d] rd_en", i),     s_rd_en,     vt[i].e_rd_en);
      if (vt[i].e_rd_en) check($sformatf("t1[%0d] rd_addr", i), s_rd_addr, vt[i].e_addr);
      check($sformatf("t1[%0d] out_valid", i), s_out_valid, vt[i].e_vld);
      check($sformatf("t1[%0d] out_data", i),  s_out_data,  vt[i].e_dat);
      check($sformatf("t1[%0d] out_bx", i),    s_out_bx,    2'd0);
      check($sformatf("t1[%0d] done", i),      s_done,      vt[i].e_done);
      check($sformatf("t1[%0d] trunc", i),     s_trunc,     vt[i].e_trunc);
    end

    // empty page: bx 1->2 reads page 1 with nent=0
    clear_stats();
    bx_in = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3[%0d] done", i), s_done, (i == 2));
    end
    check("t3 rd_cycles", rd_cycles, 0);
    check("t3 valid_cycles", valid_cycles, 0);

    // full page with ready toggling: order, no duplicates, credit respected
    for (int a = 0; a < RD; a++) mem[0][a] = 32'h2000_0000 + a;
    nent_all = {5'd0, 5'd16};
    clear_stats();
    exp_page = 1'b0;
    out_ready = 1'b1;
    bx_in = 2'd3;
    run_until_done(300, 2);
    check("t2 done", done_cnt, 1);
    check("t2 count", got_q.size(), 16);
    for (int i = 0; i < RD && i < got_q.size(); i++)
      check($sformatf("t2 word%0d", i), got_q[i], {2'd2, mem[0][i]});
    check("t2 credit", credit_viol, 0);
    check("t2 stable", stab_viol, 0);
    check("t2 trunc", trunc_cnt, 0);

    // abort: bx changes while page 1 is stalled in the FIFO
    for (int a = 0; a < RD; a++) begin
      mem[0][a] = 32'h4000_0000 + a;
      mem[1][a] = 32'h4100_0000 + a;
    end
    nent_all = {5'd16, 5'd16};
    clear_stats();
    out_ready = 1'b0;
    bx_in = 2'd0;
    repeat (8) tick();
    check("t4 stalled valid", s_out_valid, 1);
    check("t4 stalled bx", s_out_bx, 2'd3);
    bx_in = 2'd1;
    tick();
    check("t4 trunc", s_trunc, 1);
    check("t4 no done", done_cnt, 0);
    clear_stats();
    exp_page = 1'b0;
    tick();
    check("t4 flushed", s_out_valid, 0);
    check("t4 new bx", s_out_bx, 2'd0);
    out_ready = 1'b1;
    run_until_done(200, 0);
    check("t4 first addr", first_addr, 0);
    check("t4 done", done_cnt, 1);
    check("t4 count", got_q.size(), 16);
    for (int i = 0; i < RD && i < got_q.size(); i++)
      check($sformatf("t4 word%0d", i), got_q[i], {2'd0, mem[0][i]});
    check("t4 page", page_viol, 0);
    check("t4 credit", credit_viol, 0);

    // en_proc low ignores BX changes; then wrap 3->0 reads page 1
    clear_stats();
    en_proc = 1'b0;
    bx_in = 2'd2;
    tick();
    bx_in = 2'd3;
    repeat (4) tick();
    check("t5 disabled activity", rd_cycles + valid_cycles + done_cnt + trunc_cnt, 0);
    nent_all = {5'd2, 5'd16};
    en_proc = 1'b1;
    clear_stats();
    exp_page = 1'b1;
    bx_in = 2'd0;
    run_until_done(100, 0);
    check("t5 done", done_cnt, 1);
    check("t5 reads", rd_cycles, 2);
    check("t5 page", page_viol, 0);
    check("t5 count", got_q.size(), 2);
    for (int i = 0; i < 2 && i < got_q.size(); i++)
      check($sformatf("t5 word%0d", i), got_q[i], {2'd3, mem[1][i]});

    // reset with two reads in flight
    nent_all = {5'd16, 5'd16};
    clear_stats();
    exp_page = 1'b0;
    bx_in = 2'd1;
    tick(); tick(); tick();
    check("t6 in flight", issued, 2);
    reset = 1'b1;
    bx_in = 2'd0;
    tick();
    reset = 1'b0;
    clear_stats();
    tick();
    check_all_zero("t6 post-reset");
    repeat (10) tick();
    check("t6 no stale data", valid_cycles, 0);
    check("t6 no reads", rd_cycles, 0);

    // randomized readouts against a list-based reference
    for (int it = 0; it < 30; it++) begin
      int cur, nxt, n0, n1, ncl;
      logic [33:0] exp_q[$];
      for (int p = 0; p < PG; p++)
        for (int a = 0; a < RD; a++) mem[p][a] = $urandom;
      n0 = $urandom_range(0, 20);
      n1 = $urandom_range(0, 20);
      nent_all = {5'(n1), 5'(n0)};
      cur = int'(bx_in);
      nxt = $urandom_range(0, 3);
      clear_stats();
      exp_page = 1'(cur % PG);
      ncl = (cur % PG == 1) ? n1 : n0;
      if (ncl > RD) ncl = RD;
      exp_q.delete();
      if (nxt != cur)
        for (int i = 0; i < ncl; i++) exp_q.push_back({2'(cur), mem[cur % PG][i]});
      bx_in = 2'(nxt);
      run_until_done((nxt != cur) ? 400 : 6, 1);
      check($sformatf("r%0d done", it), done_cnt, (nxt != cur) ? 1 : 0);
      check($sformatf("r%0d trunc", it), trunc_cnt, 0);
      check($sformatf("r%0d count", it), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check($sformatf("r%0d word%0d", it, i), got_q[i], exp_q[i]);
      check($sformatf("r%0d credit", it), credit_viol, 0);
      check($sformatf("r%0d stable", it), stab_viol, 0);
      check($sformatf("r%0d page", it), page_viol, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
